// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle RV32I controller and its datapath.
// The master modport is the controller side; the slave modport is the datapath/memory side.
interface multicycle_controller_if #(
  parameter int RET_W = 32
);
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7b5;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             AdrSrc;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic             RegWrite;
  logic [1:0]       ResultSrc;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic [1:0]       ImmSrc;
  logic             illegal;
  logic [3:0]       state_o;
  logic [RET_W-1:0] instr_retired;

  // Handshake: a memory access is in flight in every cycle mem_req is high and completes
  // in the cycle mem_ready is sampled high; the controller holds its state until then.
  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state_o, instr_retired
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  mem_req, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, illegal, state_o, instr_retired
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for the multicycle RV32I core: sequences the shared ALU,
// the unified memory port and the register file, with wait states, trap and retire count.
module multicycle_controller #(
  parameter int RET_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [RET_W-1:0] ret_q, ret_d;

  logic       mem_req, adr_src, mem_write, ir_write, reg_write;
  logic       branch, pc_update, retire;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] alu_ctl;
  logic [1:0] imm_src;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      ret_q     <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      ret_q     <= ret_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    branch     = 1'b0;
    pc_update  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm is computed here so BEQ can load the target from ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1101111:             state_d = S_JAL;
          7'b1100011:             state_d = S_BEQ;
          default:                state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (bus.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC+4 for the link.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  always_comb begin
    illegal_d = illegal_q | (state_d == S_TRAP);
    ret_d     = ret_q + RET_W'(retire);
  end

  always_comb begin
    alu_ctl = 3'b000;
    case (alu_op)
      2'b01: alu_ctl = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_ctl = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctl = 3'b101;
          3'b110:  alu_ctl = 3'b011;
          3'b111:  alu_ctl = 3'b010;
          default: alu_ctl = 3'b000;
        endcase
      end
      default: alu_ctl = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.op)
      7'b0100011: imm_src = 2'b01;
      7'b1100011: imm_src = 2'b10;
      7'b1101111: imm_src = 2'b11;
      default:    imm_src = 2'b00;
    endcase
  end

  // Write strobes are gated by reset so nothing can write while reset is asserted.
  assign bus.mem_req       = mem_req;
  assign bus.AdrSrc        = adr_src;
  assign bus.MemWrite      = mem_write & rst;
  assign bus.IRWrite       = ir_write & rst;
  assign bus.PCWrite       = ((branch & bus.zero) | pc_update) & rst;
  assign bus.RegWrite      = reg_write & rst;
  assign bus.ResultSrc     = result_src;
  assign bus.ALUSrcA       = alu_src_a;
  assign bus.ALUSrcB       = alu_src_b;
  assign bus.ALUControl    = alu_ctl;
  assign bus.ImmSrc        = imm_src;
  assign bus.illegal       = illegal_q;
  assign bus.state_o       = state_q;
  assign bus.instr_retired = ret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class through its
// state sequence, checking per-cycle controls, wait states, trap and reset behaviour.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_ret;

  always #5 clk = ~clk;

  multicycle_controller_if #(.RET_W(32)) bus ();

  multicycle_controller #(.RET_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  task automatic test_reset();
    rst = 1'b0;
    bus.op = 7'b0000011;
    bus.funct3 = 3'b000;
    bus.funct7b5 = 1'b0;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b1;
    #3;
    checks++;
    if (bus.state_o !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.state_o); end
    checks++;
    if ({bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite} !== 4'b0000) begin
      failures++; $display("FAIL reset_enables got=%b exp=0000", {bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite});
    end
    checks++;
    if (bus.illegal !== 1'b0 || bus.instr_retired !== 32'd0) begin
      failures++; $display("FAIL reset_flags illegal=%b ret=%0d exp 0/0", bus.illegal, bus.instr_retired);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.state_o !== 4'd0) begin failures++; $display("FAIL reset_hold got=%0d exp=0", bus.state_o); end
    rst = 1'b1;
    exp_ret = 32'd0;
  endtask

  task automatic test_lw();
    logic [3:0] es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    for (int i = 0; i < 6; i++) begin
      #1;
      bus.op = 7'b0000011;
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state_o !== es[i]) begin failures++; $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, bus.state_o, es[i]); end
      checks++;
      if (bus.RegWrite !== (es[i] == 4'd4)) begin failures++; $display("FAIL lw_regwrite cyc=%0d got=%b", i, bus.RegWrite); end
      if (es[i] == 4'd4) begin
        checks++;
        if (bus.ResultSrc !== 2'b01) begin failures++; $display("FAIL lw_resultsrc got=%b exp=01", bus.ResultSrc); end
      end
      if (i < 5) @(posedge clk);
    end
    exp_ret = exp_ret + 1;
    checks++;
    if (bus.instr_retired !== exp_ret) begin failures++; $display("FAIL lw_retired got=%0d exp=%0d", bus.instr_retired, exp_ret); end
  endtask

  // lw with two fetch wait cycles and one read wait cycle.
  task automatic test_lw_wait();
    logic [3:0] es [9] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd0};
    logic       rd [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      #1;
      bus.op = 7'b0000011;
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state_o !== es[i]) begin failures++; $display("FAIL lw_wait_state cyc=%0d got=%0d exp=%0d", i, bus.state_o, es[i]); end
      if (es[i] == 4'd0 && i < 8) begin
        checks++;
        if (bus.IRWrite !== rd[i] || bus.PCWrite !== rd[i] || bus.mem_req !== 1'b1) begin
          failures++; $display("FAIL lw_wait_fetch cyc=%0d ir=%b pc=%b req=%b exp ir=pc=%b req=1", i, bus.IRWrite, bus.PCWrite, bus.mem_req, rd[i]);
        end
      end
      if (i < 8) @(posedge clk);
    end
    exp_ret = exp_ret + 1;
    checks++;
    if (bus.instr_retired !== exp_ret) begin failures++; $display("FAIL lw_wait_retired got=%0d exp=%0d", bus.instr_retired, exp_ret); end
  endtask

  task automatic test_sw();
    logic [3:0] es [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic       rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      #1;
      bus.op = 7'b0100011;
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state_o !== es[i]) begin failures++; $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, bus.state_o, es[i]); end
      checks++;
      if (bus.MemWrite !== (es[i] == 4'd5) || bus.AdrSrc !== (es[i] == 4'd5)) begin
        failures++; $display("FAIL sw_memwrite cyc=%0d mw=%b adr=%b", i, bus.MemWrite, bus.AdrSrc);
      end
      checks++;
      if (bus.ImmSrc !== 2'b01) begin failures++; $display("FAIL sw_immsrc cyc=%0d got=%b exp=01", i, bus.ImmSrc); end
      if (i < 7) @(posedge clk);
    end
    exp_ret = exp_ret + 1;
    checks++;
    if (bus.instr_retired !== exp_ret) begin failures++; $display("FAIL sw_retired got=%0d exp=%0d", bus.instr_retired, exp_ret); end
  endtask

  task automatic test_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [2:0] exp_ctl);
    logic [3:0] ex;
    logic [3:0] es [5];
    ex = (op == 7'b0110011) ? 4'd6 : 4'd7;
    es = '{4'd0, 4'd1, ex, 4'd8, 4'd0};
    for (int i = 0; i < 5; i++) begin
      #1;
      bus.op = op;
      bus.funct3 = f3;
      bus.funct7b5 = f7;
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state_o !== es[i]) begin failures++; $display("FAIL alu_state op=%b cyc=%0d got=%0d exp=%0d", op, i, bus.state_o, es[i]); end
      if (i == 2) begin
        checks++;
        if (bus.ALUControl !== exp_ctl) begin
          failures++; $display("FAIL alu_ctl op=%b f3=%b f7=%b got=%b exp=%b", op, f3, f7, bus.ALUControl, exp_ctl);
        end
      end
      if (i == 3) begin
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.ResultSrc !== 2'b00) begin
          failures++; $display("FAIL alu_wb got rw=%b rs=%b exp 1/00", bus.RegWrite, bus.ResultSrc);
        end
      end
      if (i < 4) @(posedge clk);
    end
    exp_ret = exp_ret + 1;
    checks++;
    if (bus.instr_retired !== exp_ret) begin failures++; $display("FAIL alu_retired got=%0d exp=%0d", bus.instr_retired, exp_ret); end
  endtask

  task automatic test_beq(input logic z);
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd10, 4'd0};
    logic       pw;
    for (int i = 0; i < 4; i++) begin
      #1;
      bus.op = 7'b1100011;
      bus.zero = z;
      bus.mem_ready = 1'b1;
      #1;
      pw = (es[i] == 4'd0) ? 1'b1 : ((es[i] == 4'd10) ? z : 1'b0);
      checks++;
      if (bus.state_o !== es[i]) begin failures++; $display("FAIL beq_state z=%b cyc=%0d got=%0d exp=%0d", z, i, bus.state_o, es[i]); end
      checks++;
      if (bus.PCWrite !== pw) begin failures++; $display("FAIL beq_pcwrite z=%b cyc=%0d got=%b exp=%b", z, i, bus.PCWrite, pw); end
      if (es[i] == 4'd10) begin
        checks++;
        if (bus.ALUControl !== 3'b001 || bus.ImmSrc !== 2'b10) begin
          failures++; $display("FAIL beq_alu got ctl=%b imm=%b exp 001/10", bus.ALUControl, bus.ImmSrc);
        end
      end
      if (i < 3) @(posedge clk);
    end
    bus.zero = 1'b0;
    exp_ret = exp_ret + 1;
    checks++;
    if (bus.instr_retired !== exp_ret) begin failures++; $display("FAIL beq_retired got=%0d exp=%0d", bus.instr_retired, exp_ret); end
  endtask

  task automatic test_jal();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd9, 4'd8, 4'd0};
    for (int i = 0; i < 5; i++) begin
      #1;
      bus.op = 7'b1101111;
      bus.mem_ready = 1'b1;
      #1;
      checks++;
      if (bus.state_o !== es[i]) begin failures++; $display("FAIL jal_state cyc=%0d got=%0d exp=%0d", i, bus.state_o, es[i]); end
      checks++;
      if (bus.ImmSrc !== 2'b11) begin failures++; $display("FAIL jal_immsrc cyc=%0d got=%b exp=11", i, bus.ImmSrc); end
      if (es[i] == 4'd9) begin
        checks++;
        if (bus.PCWrite !== 1'b1 || bus.RegWrite !== 1'b0) begin failures++; $display("FAIL jal_pcwrite pc=%b rw=%b exp 1/0", bus.PCWrite, bus.RegWrite); end
      end
      if (es[i] == 4'd8) begin
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.PCWrite !== 1'b0) begin failures++; $display("FAIL jal_link rw=%b pc=%b exp 1/0", bus.RegWrite, bus.PCWrite); end
      end
      if (i < 4) @(posedge clk);
    end
    exp_ret = exp_ret + 1;
    checks++;
    if (bus.instr_retired !== exp_ret) begin failures++; $display("FAIL jal_retired got=%0d exp=%0d", bus.instr_retired, exp_ret); end
  endtask

  // Reset asserted while a store is waiting in MEMWRITE must kill the strobe at once.
  task automatic test_reset_mid();
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    logic       rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      #1;
      bus.op = 7'b0100011;
      bus.mem_ready = rd[i];
      #1;
      checks++;
      if (bus.state_o !== es[i]) begin failures++; $display("FAIL rstmid_state cyc=%0d got=%0d exp=%0d", i, bus.state_o, es[i]); end
      if (i < 3) @(posedge clk);
    end
    checks++;
    if (bus.MemWrite !== 1'b1) begin failures++; $display("FAIL rstmid_pre_mw got=%b exp=1", bus.MemWrite); end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 4'd0 || bus.MemWrite !== 1'b0 || bus.instr_retired !== 32'd0) begin
      failures++; $display("FAIL rstmid_async state=%0d mw=%b ret=%0d exp 0/0/0", bus.state_o, bus.MemWrite, bus.instr_retired);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_ret = 32'd0;
  endtask

  task automatic test_trap();
    logic [3:0] es;
    for (int i = 0; i < 24; i++) begin
      #1;
      bus.op = 7'b1111111;
      bus.mem_ready = 1'b1;
      bus.zero = 1'b1;
      #1;
      es = (i < 2) ? 4'(i) : 4'd11;
      checks++;
      if (bus.state_o !== es) begin failures++; $display("FAIL trap_state cyc=%0d got=%0d exp=%0d", i, bus.state_o, es); end
      if (i >= 2) begin
        checks++;
        if (bus.illegal !== 1'b1) begin failures++; $display("FAIL trap_illegal cyc=%0d got=%b exp=1", i, bus.illegal); end
        checks++;
        if ({bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite} !== 5'b00000) begin
          failures++; $display("FAIL trap_enables cyc=%0d got=%b exp=00000", i, {bus.mem_req, bus.MemWrite, bus.IRWrite, bus.PCWrite, bus.RegWrite});
        end
        checks++;
        if (bus.instr_retired !== exp_ret) begin failures++; $display("FAIL trap_counter cyc=%0d got=%0d exp=%0d", i, bus.instr_retired, exp_ret); end
      end
      if (i < 23) @(posedge clk);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.state_o !== 4'd0 || bus.illegal !== 1'b0) begin
      failures++; $display("FAIL trap_reset state=%0d illegal=%b exp 0/0", bus.state_o, bus.illegal);
    end
    checks++;
    if (bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin
      failures++; $display("FAIL trap_reset_gate ir=%b pc=%b exp 0/0", bus.IRWrite, bus.PCWrite);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.zero = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_lw_wait();
    test_sw();
    test_alu(7'b0110011, 3'b000, 1'b1, 3'b001);
    test_alu(7'b0110011, 3'b000, 1'b0, 3'b000);
    test_alu(7'b0010011, 3'b000, 1'b1, 3'b000);
    test_alu(7'b0110011, 3'b010, 1'b0, 3'b101);
    test_alu(7'b0010011, 3'b110, 1'b0, 3'b011);
    test_alu(7'b0110011, 3'b111, 1'b0, 3'b010);
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_reset_mid();
    test_lw();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
